// File: rtl/rr_arb_hold.sv
// Round-robin arbiter with bounded grant hold.
// One requester owns the shared resource at a time. A grant ends when the owner
// signals done, when its request drops, or when the hold limit forces it off.
// Every release is followed by at least one idle cycle. The search pointer
// moves past the last winner, so that winner has the lowest priority next time.
module rr_arb_hold #(
  parameter int N        = 7,
  parameter int MAX_HOLD = 15
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N-1:0]         req,
  input  logic                 done,
  output logic [N-1:0]         grant,
  output logic [$clog2(N)-1:0] grant_id,
  output logic                 busy,
  output logic                 timeout
);

  localparam int IW = $clog2(N);
  localparam int HW = $clog2(MAX_HOLD);

  localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(N - 1);
  localparam logic [IW:0]   N_WIDE    = (IW+1)'(N);
  localparam logic [N-1:0]  ONE_HOT0  = N'(1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_OWN  = 1'b1
  } state_e;

  // Registered state and outputs
  state_e        r_state;
  logic [N-1:0]  r_grant;
  logic [IW-1:0] r_grant_id;
  logic          r_busy;
  logic          r_timeout;
  logic [IW-1:0] r_ptr;
  logic [HW-1:0] r_hold;

  // Next-state values
  state_e        w_state_nxt;
  logic [N-1:0]  w_grant_nxt;
  logic [IW-1:0] w_grant_id_nxt;
  logic          w_busy_nxt;
  logic          w_timeout_nxt;
  logic [IW-1:0] w_ptr_nxt;
  logic [HW-1:0] w_hold_nxt;

  // Arbitration and release terms
  logic          w_found;
  logic [IW-1:0] w_sel;
  logic          w_owner_req;
  logic          w_hold_last;
  logic          w_release;
  logic          w_forced;

  // Circular search: first set request at or after r_ptr, wrapping N-1 -> 0.
  always_comb begin
    logic [IW:0] w_sum;
    logic [IW-1:0] w_idx;
    // NOTE: every variable written here gets a default first so that no path
    // leaves it unassigned; a missing default would infer a latch.
    w_found = 1'b0;
    w_sel   = '0;
    w_sum   = '0;
    w_idx   = '0;
    for (int i = 0; i < N; i++) begin
      w_sum = {1'b0, r_ptr} + (IW+1)'(i);
      if (w_sum >= N_WIDE) begin
        w_sum = w_sum - N_WIDE;
      end
      w_idx = w_sum[IW-1:0];
      if (!w_found && req[w_idx]) begin
        w_found = 1'b1;
        w_sel   = w_idx;
      end
    end
  end

  // Release conditions while owning: done, owner request dropped, hold limit.
  always_comb begin
    w_owner_req = |(req & r_grant);
    w_hold_last = (r_hold == HOLD_LAST);
    w_release   = done | ~w_owner_req | w_hold_last;
    // A forced release is one where nothing but the hold limit ended the grant.
    w_forced    = w_hold_last & ~done & w_owner_req;
  end

  // Next-state and next-output logic for the IDLE/OWN machine.
  always_comb begin
    w_state_nxt    = r_state;
    w_grant_nxt    = r_grant;
    w_grant_id_nxt = r_grant_id;
    w_ptr_nxt      = r_ptr;
    w_hold_nxt     = r_hold;
    w_timeout_nxt  = 1'b0;

    case (r_state)
      S_IDLE: begin
        // done is deliberately ignored here; only requests start a grant.
        if (w_found) begin
          w_state_nxt    = S_OWN;
          w_grant_nxt    = ONE_HOT0 << w_sel;
          w_grant_id_nxt = w_sel;
          w_ptr_nxt      = (w_sel == IDX_LAST) ? '0 : w_sel + IW'(1);
          w_hold_nxt     = '0;
        end
      end

      S_OWN: begin
        // Other requesters are not looked at while a grant is held.
        if (w_release) begin
          w_state_nxt    = S_IDLE;
          w_grant_nxt    = '0;
          w_grant_id_nxt = '0;
          w_hold_nxt     = '0;
          w_timeout_nxt  = w_forced;
        end else begin
          w_hold_nxt = r_hold + HW'(1);
        end
      end

      default: begin
        w_state_nxt    = S_IDLE;
        w_grant_nxt    = '0;
        w_grant_id_nxt = '0;
        w_hold_nxt     = '0;
      end
    endcase

    w_busy_nxt = (w_state_nxt == S_OWN);
  end

  // State, pointer, hold counter and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: reset is asynchronous so that grant drops the moment rst_n falls,
    // even mid-grant; every register here is reset, no timeout is produced.
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_grant    <= '0;
      r_grant_id <= '0;
      r_busy     <= 1'b0;
      r_timeout  <= 1'b0;
      r_ptr      <= '0;
      r_hold     <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      r_state    <= w_state_nxt;
      r_grant    <= w_grant_nxt;
      r_grant_id <= w_grant_id_nxt;
      r_busy     <= w_busy_nxt;
      r_timeout  <= w_timeout_nxt;
      r_ptr      <= w_ptr_nxt;
      r_hold     <= w_hold_nxt;
    end
  end

  assign grant    = r_grant;
  assign grant_id = r_grant_id;
  assign busy     = r_busy;
  assign timeout  = r_timeout;

  // Consistency of the registered outputs.
  a_grant_onehot0 : assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0(r_grant));
  a_busy_matches : assert property (@(posedge clk) disable iff (!rst_n)
    r_busy == (r_grant != '0));
  a_id_matches : assert property (@(posedge clk) disable iff (!rst_n)
    r_busy |-> (r_grant == (ONE_HOT0 << r_grant_id)));
  a_idle_id_zero : assert property (@(posedge clk) disable iff (!rst_n)
    !r_busy |-> (r_grant_id == '0));
  a_timeout_idle : assert property (@(posedge clk) disable iff (!rst_n)
    r_timeout |-> !r_busy);

endmodule

// File: tb/tb_rr_arb_hold.sv
// Testbench for rr_arb_hold. A cycle-level reference model predicts grant,
// grant_id, busy and timeout for every driven cycle; a monitor compares them
// after each rising edge. Scenario tasks also check fixed expected values.
module tb_rr_arb_hold;

  localparam int N        = 7;
  localparam int MAX_HOLD = 15;
  localparam int IW       = $clog2(N);

  logic          clk = 1'b0;
  logic          rst_n;
  logic [N-1:0]  req;
  logic          done;
  logic [N-1:0]  grant;
  logic [IW-1:0] grant_id;
  logic          busy;
  logic          timeout;

  typedef struct packed {
    logic [N-1:0]  grant;
    logic [IW-1:0] id;
    logic          busy;
    logic          to;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_pass   = 0;

  // Reference model state: owner index (-1 when idle), search start, cycles held.
  int m_owner;
  int m_ptr;
  int m_len;

  rr_arb_hold #(.N(N), .MAX_HOLD(MAX_HOLD)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .done     (done),
    .grant    (grant),
    .grant_id (grant_id),
    .busy     (busy),
    .timeout  (timeout)
  );

  always #5 clk = ~clk;

  function automatic void model_reset();
    m_owner = -1;
    m_ptr   = 0;
    m_len   = 0;
  endfunction

  // Predict the outputs after the next rising edge for inputs r/d.
  function automatic void model_step(input logic [N-1:0] r, input logic d);
    exp_t e;
    e = '0;
    if (m_owner < 0) begin
      for (int i = 0; i < N; i++) begin
        int j;
        j = (m_ptr + i) % N;
        if (m_owner < 0 && ((r & (N'(1) << j)) != '0)) m_owner = j;
      end
      if (m_owner >= 0) begin
        m_ptr = (m_owner + 1) % N;
        m_len = 1;
      end
    end else if (d || ((r & (N'(1) << m_owner)) == '0)) begin
      m_owner = -1;
    end else if (m_len == MAX_HOLD) begin
      m_owner = -1;
      e.to    = 1'b1;
    end else begin
      m_len++;
    end
    if (m_owner >= 0) begin
      e.grant = N'(1) << m_owner;
      e.id    = IW'(m_owner);
      e.busy  = 1'b1;
    end
    sb_q.push_back(e);
  endfunction

  // Drive one cycle of stimulus (called just after a falling edge).
  task automatic cycle(input logic [N-1:0] r, input logic d);
    req  = r;
    done = d;
    model_step(r, d);
    @(negedge clk);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Scoreboard monitor: compare DUT outputs shortly after each rising edge.
  always @(posedge clk) begin
    #2;
    if (sb_q.size() != 0) begin
      mon_e = sb_q.pop_front();
      n_checks++;
      if ({grant, grant_id, busy, timeout} !== mon_e)
        $display("FAIL scoreboard t=%0t got grant=%b id=%0d busy=%b to=%b want grant=%b id=%0d busy=%b to=%b",
                 $time, grant, grant_id, busy, timeout,
                 mon_e.grant, mon_e.id, mon_e.busy, mon_e.to);
      else n_pass++;
    end
  end

  task automatic test_reset();
    rst_n = 1'b0;
    req   = '0;
    done  = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    n_checks++; if (grant !== 7'b0) $display("FAIL reset_grant got %b want 0", grant); else n_pass++;
    n_checks++; if (grant_id !== 3'd0) $display("FAIL reset_id got %0d want 0", grant_id); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else n_pass++;
    n_checks++; if (timeout !== 1'b0) $display("FAIL reset_timeout got %b want 0", timeout); else n_pass++;
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    cycle(7'b0001010, 1'b0);
    n_checks++; if (grant !== 7'b0000010) $display("FAIL basic_grant1 got %b want 0000010", grant); else n_pass++;
    n_checks++; if (grant_id !== 3'd1) $display("FAIL basic_id1 got %0d want 1", grant_id); else n_pass++;
    n_checks++; if (busy !== 1'b1) $display("FAIL basic_busy got %b want 1", busy); else n_pass++;
    cycle(7'b0001010, 1'b1);
    n_checks++; if (grant !== 7'b0) $display("FAIL basic_gap got %b want 0", grant); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL basic_gap_busy got %b want 0", busy); else n_pass++;
    cycle(7'b0001010, 1'b0);
    n_checks++; if (grant !== 7'b0001000) $display("FAIL basic_grant3 got %b want 0001000", grant); else n_pass++;
    n_checks++; if (grant_id !== 3'd3) $display("FAIL basic_id3 got %0d want 3", grant_id); else n_pass++;
    cycle(7'b0001010, 1'b1);
    n_checks++; if (timeout !== 1'b0) $display("FAIL basic_done_timeout got %b want 0", timeout); else n_pass++;
    cycle(7'b0000000, 1'b0);
  endtask

  task automatic test_timeout();
    int held;
    held = 0;
    for (int i = 0; i < MAX_HOLD; i++) begin
      cycle(7'b0000001, 1'b0);
      if (grant === 7'b0000001) held++;
    end
    n_checks++; if (held != 15) $display("FAIL timeout_hold_len got %0d want 15", held); else n_pass++;
    cycle(7'b0000001, 1'b0);
    n_checks++; if (grant !== 7'b0) $display("FAIL timeout_gap got %b want 0", grant); else n_pass++;
    n_checks++; if (timeout !== 1'b1) $display("FAIL timeout_pulse got %b want 1", timeout); else n_pass++;
    cycle(7'b0000001, 1'b0);
    n_checks++; if (grant !== 7'b0000001) $display("FAIL timeout_regrant got %b want 0000001", grant); else n_pass++;
    n_checks++; if (timeout !== 1'b0) $display("FAIL timeout_one_cycle got %b want 0", timeout); else n_pass++;
    cycle(7'b0000000, 1'b0);
    n_checks++; if (timeout !== 1'b0) $display("FAIL timeout_drop got %b want 0", timeout); else n_pass++;
    cycle(7'b0000000, 1'b0);
  endtask

  task automatic test_fairness();
    apply_reset();
    for (int i = 0; i < 8; i++) begin
      cycle(7'h7F, 1'b1);
      n_checks++;
      if (grant_id !== IW'(i % N) || busy !== 1'b1)
        $display("FAIL fair_id%0d got id=%0d busy=%b want id=%0d busy=1", i, grant_id, busy, i % N);
      else n_pass++;
      cycle(7'h7F, 1'b1);
      n_checks++;
      if (grant !== 7'b0) $display("FAIL fair_gap%0d got %b want 0", i, grant); else n_pass++;
    end
    cycle(7'b0000000, 1'b0);
  endtask

  task automatic test_wrap();
    apply_reset();
    cycle(7'b0100000, 1'b0);
    n_checks++; if (grant_id !== 3'd5) $display("FAIL wrap_id5 got %0d want 5", grant_id); else n_pass++;
    cycle(7'b0100000, 1'b1);
    cycle(7'b1000001, 1'b0);
    n_checks++; if (grant_id !== 3'd6) $display("FAIL wrap_id6 got %0d want 6", grant_id); else n_pass++;
    cycle(7'b1000001, 1'b1);
    n_checks++; if (grant !== 7'b0) $display("FAIL wrap_gap got %b want 0", grant); else n_pass++;
    cycle(7'b1000001, 1'b0);
    n_checks++; if (grant !== 7'b0000001) $display("FAIL wrap_grant0 got %b want 0000001", grant); else n_pass++;
    cycle(7'b0000000, 1'b1);
  endtask

  task automatic test_drop();
    logic [N-1:0] other;
    cycle(7'b0000100, 1'b0);
    n_checks++; if (grant_id !== 3'd2) $display("FAIL drop_id2 got %0d want 2", grant_id); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      other = N'($urandom) | 7'b0000100;
      cycle(other, 1'b0);
      n_checks++;
      if (grant !== 7'b0000100) $display("FAIL drop_others%0d got %b want 0000100", i, grant); else n_pass++;
    end
    cycle(7'b0011000, 1'b0);
    n_checks++; if (grant !== 7'b0) $display("FAIL drop_release got %b want 0", grant); else n_pass++;
    n_checks++; if (timeout !== 1'b0) $display("FAIL drop_timeout got %b want 0", timeout); else n_pass++;
    cycle(7'b0011000, 1'b0);
    n_checks++; if (grant_id !== 3'd3) $display("FAIL drop_id3 got %0d want 3", grant_id); else n_pass++;
    for (int i = 0; i < MAX_HOLD - 1; i++) cycle(7'b0001000, 1'b0);
    n_checks++; if (grant !== 7'b0001000) $display("FAIL drop_last_cycle got %b want 0001000", grant); else n_pass++;
    cycle(7'b0001000, 1'b1);
    n_checks++; if (grant !== 7'b0) $display("FAIL drop_done_limit got %b want 0", grant); else n_pass++;
    n_checks++; if (timeout !== 1'b0) $display("FAIL drop_done_limit_to got %b want 0", timeout); else n_pass++;
    cycle(7'b0000000, 1'b0);
  endtask

  task automatic test_reset_mid();
    cycle(7'b0010000, 1'b0);
    n_checks++; if (grant !== 7'b0010000) $display("FAIL mid_grant4 got %b want 0010000", grant); else n_pass++;
    cycle(7'b0010000, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++; if (grant !== 7'b0) $display("FAIL mid_async_grant got %b want 0", grant); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL mid_async_busy got %b want 0", busy); else n_pass++;
    n_checks++; if (timeout !== 1'b0) $display("FAIL mid_async_timeout got %b want 0", timeout); else n_pass++;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    cycle(7'h7F, 1'b0);
    n_checks++; if (grant_id !== 3'd0) $display("FAIL mid_first_id got %0d want 0", grant_id); else n_pass++;
    n_checks++; if (grant !== 7'b0000001) $display("FAIL mid_first_grant got %b want 0000001", grant); else n_pass++;
    cycle(7'h7F, 1'b1);
    cycle(7'b0000000, 1'b0);
  endtask

  task automatic test_random();
    logic [N-1:0] r;
    logic         d;
    r = '0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) r = N'($urandom);
      d = ($urandom_range(0, 9) == 0);
      cycle(r, d);
    end
    cycle(7'b0000000, 1'b0);
    cycle(7'b0000000, 1'b0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_timeout();
    test_fairness();
    test_wrap();
    test_drop();
    test_reset_mid();
    test_random();
    n_checks++;
    if (sb_q.size() != 0) $display("FAIL scoreboard_drain got %0d pending want 0", sb_q.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
